if_id_skid_reg: RTL

//   IF/ID pipeline register: the producer of ifid_out, the instruction word that
//   the ID stage (sign extension, register decode) consumes.

---
 rtl/if_id_skid_reg.sv | 81 ++++++++
 1 files changed

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer, flush-to-bubble
// and a saturating ID stall-cycle counter.
module if_id_skid_reg #(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] NOP   = {WIDTH{1'b0}},
   parameter int               CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_valid,
   output logic             if_ready,
   input  logic [WIDTH-1:0] if_instr,
   input  logic [WIDTH-1:0] if_pc4,
   input  logic             id_stall,
   input  logic             flush,
   output logic [WIDTH-1:0] ifid_out,
   output logic [WIDTH-1:0] ifid_pc4,
   output logic             ifid_valid,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             skid_valid;
   logic [WIDTH-1:0] skid_instr;
   logic [WIDTH-1:0] skid_pc4;
   logic             acc;
   logic             con;

   // Ready depends on registered state only, never on id_stall.
   assign if_ready = !skid_valid;
   assign acc      = if_valid & if_ready;
   assign con      = ifid_valid & !id_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_out   <= NOP;
         ifid_pc4   <= '0;
         ifid_valid <= 1'b0;
         skid_valid <= 1'b0;
         skid_instr <= '0;
         skid_pc4   <= '0;
      end else if (flush) begin
         ifid_out   <= NOP;
         ifid_pc4   <= '0;
         ifid_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!ifid_valid) begin
         if (acc) begin
            ifid_out   <= if_instr;
            ifid_pc4   <= if_pc4;
            ifid_valid <= 1'b1;
         end
      end else if (con) begin
         if (skid_valid) begin
            ifid_out   <= skid_instr;
            ifid_pc4   <= skid_pc4;
            skid_valid <= 1'b0;
         end else if (acc) begin
            ifid_out   <= if_instr;
            ifid_pc4   <= if_pc4;
         end else begin
            ifid_out   <= NOP;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
         end
      end else if (acc) begin
         // Main is stalled: the younger word parks in the skid entry.
         skid_instr <= if_instr;
         skid_pc4   <= if_pc4;
         skid_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (ifid_valid && id_stall && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
